// File: rtl/exec_result_select.sv
// rtl/exec_result_select.sv - execute-stage result selector over NUM_SRC variable-latency units
module exec_result_select #(
  parameter int XLEN        = 32,
  parameter int NUM_SRC     = 3,
  parameter int TIMEOUT_CYC = 64,
  localparam int SEL_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issueValid,
  output logic                    issueReady,
  input  logic [SEL_W-1:0]        issueSel,
  input  logic [4:0]              issueRd,
  input  logic [NUM_SRC-1:0]      srcValid,
  input  logic [NUM_SRC*XLEN-1:0] srcData,
  output logic                    wbValid,
  input  logic                    wbReady,
  output logic [XLEN-1:0]         wbData,
  output logic [4:0]              wbRd,
  output logic                    wbErr,
  output logic                    stall
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SEL_W:0] NUM_SRC_V = (SEL_W + 1)'(NUM_SRC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t            state_q, state_n;
  logic [SEL_W-1:0]  sel_q, sel_n;
  logic [CNT_W-1:0]  cnt_q, cnt_n;
  logic [XLEN-1:0]   data_n;
  logic [4:0]        rd_n;
  logic              err_n;

  logic              accept, bad_sel;
  logic              issue_hit, wait_hit;
  logic [XLEN-1:0]   issue_data, wait_data;

  assign issueReady = (state_q == IDLE) || ((state_q == HOLD) && wbReady);
  assign accept     = issueValid && issueReady;
  assign stall      = issueValid && !issueReady;
  assign wbValid    = (state_q == HOLD);
  assign bad_sel    = {1'b0, issueSel} >= NUM_SRC_V;

  // Two independent selectors: one for the unit named by the incoming issue,
  // one for the unit latched by the op already waiting.
  always_comb begin
    issue_hit  = 1'b0;
    issue_data = '0;
    wait_hit   = 1'b0;
    wait_data  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (issueSel == SEL_W'(i)) begin
        issue_hit  = srcValid[i];
        issue_data = srcData[i*XLEN +: XLEN];
      end
      if (sel_q == SEL_W'(i)) begin
        wait_hit  = srcValid[i];
        wait_data = srcData[i*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    state_n = state_q;
    sel_n   = sel_q;
    cnt_n   = cnt_q;
    data_n  = wbData;
    rd_n    = wbRd;
    err_n   = wbErr;

    case (state_q)
      WAIT: begin
        if (wait_hit) begin
          data_n  = wait_data;
          err_n   = 1'b0;
          state_n = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          data_n  = '0;
          err_n   = 1'b1;
          state_n = HOLD;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (wbReady) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Acceptance only happens from IDLE or a draining HOLD, so it overrides both.
    if (accept) begin
      sel_n = issueSel;
      rd_n  = issueRd;
      cnt_n = '0;
      if (bad_sel) begin
        data_n  = '0;
        err_n   = 1'b1;
        state_n = HOLD;
      end else if (issue_hit) begin
        data_n  = issue_data;
        err_n   = 1'b0;
        state_n = HOLD;
      end else begin
        state_n = WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      wbData  <= '0;
      wbRd    <= '0;
      wbErr   <= 1'b0;
    end else begin
      state_q <= state_n;
      sel_q   <= sel_n;
      cnt_q   <= cnt_n;
      wbData  <= data_n;
      wbRd    <= rd_n;
      wbErr   <= err_n;
    end
  end

endmodule

// File: tb/tb_exec_result_select.sv
// tb/tb_exec_result_select.sv - scoreboard bench for exec_result_select
module tb_exec_result_select;

  localparam int XLEN = 32;
  localparam int NUM_SRC = 3;
  localparam int T = 4;

  logic                    clk;
  logic                    rst_n;
  logic                    issueValid;
  logic                    issueReady;
  logic [1:0]              issueSel;
  logic [4:0]              issueRd;
  logic [NUM_SRC-1:0]      srcValid;
  logic [NUM_SRC*XLEN-1:0] srcData;
  logic                    wbValid;
  logic                    wbReady;
  logic [XLEN-1:0]         wbData;
  logic [4:0]              wbRd;
  logic                    wbErr;
  logic                    stall;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  exec_result_select #(.XLEN(XLEN), .NUM_SRC(NUM_SRC), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .issueValid(issueValid), .issueReady(issueReady),
    .issueSel(issueSel), .issueRd(issueRd),
    .srcValid(srcValid), .srcData(srcData),
    .wbValid(wbValid), .wbReady(wbReady),
    .wbData(wbData), .wbRd(wbRd), .wbErr(wbErr),
    .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic [1:0] sel, input logic [4:0] rd);
    issueValid = 1'b1;
    issueSel   = sel;
    issueRd    = rd;
  endtask

  task automatic set_src(input int idx, input logic [31:0] d);
    srcValid[idx]          = 1'b1;
    srcData[idx*XLEN +: XLEN] = d;
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] rd, input logic err);
    exp_t e;
    e.data = d;
    e.rd   = rd;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  // Every completed writeback handshake is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && wbValid && wbReady) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'(wbRd), 64'h1f_ffff);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_data", 64'(wbData), 64'(e.data));
        chk("sb_rd",   64'(wbRd),   64'(e.rd));
        chk("sb_err",  64'(wbErr),  64'(e.err));
      end
    end
  end

  initial begin
    rst_n = 1'b0; issueValid = 1'b0; issueSel = '0; issueRd = '0;
    srcValid = '0; srcData = '0; wbReady = 1'b1;
    #2;
    chk("rst_wbValid", 64'(wbValid), 0);
    chk("rst_wbData", 64'(wbData), 0);
    chk("rst_wbRd", 64'(wbRd), 0);
    chk("rst_wbErr", 64'(wbErr), 0);
    chk("rst_issueReady", 64'(issueReady), 1);
    chk("rst_stall", 64'(stall), 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // 1: ALU op with same-cycle result
    drive_issue(2'd0, 5'd7); set_src(0, 32'h0000_00A5); push(32'hA5, 5'd7, 1'b0);
    #1 chk("t1_ready", 64'(issueReady), 1);
    step();
    issueValid = 1'b0; srcValid = '0;
    chk("t1_wbValid", 64'(wbValid), 1);
    chk("t1_wbData", 64'(wbData), 64'hA5);
    chk("t1_wbRd", 64'(wbRd), 7);
    step();
    chk("t1_done", 64'(wbValid), 0);

    // 2: MUL three cycles later, second issue stalled, then back-to-back
    drive_issue(2'd1, 5'd3); push(32'h1234_5678, 5'd3, 1'b0);
    step();
    drive_issue(2'd0, 5'd9);
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) set_src(1, 32'h1234_5678);
      #1 chk("t2_stall", 64'(stall), 1);
      chk("t2_wbValid_low", 64'(wbValid), 0);
      step();
    end
    srcValid = '0;
    chk("t2_wbValid", 64'(wbValid), 1);
    chk("t2_wbData", 64'(wbData), 64'h1234_5678);
    set_src(0, 32'h55); push(32'h55, 5'd9, 1'b0);
    #1 chk("t2_b2b_stall", 64'(stall), 0);
    step();
    issueValid = 1'b0; srcValid = '0;
    chk("t2_b2b_valid", 64'(wbValid), 1);
    chk("t2_b2b_rd", 64'(wbRd), 9);
    step();

    // 3: backpressure holds the result stable
    wbReady = 1'b0;
    drive_issue(2'd0, 5'd12); set_src(0, 32'hDEAD_BEEF); push(32'hDEAD_BEEF, 5'd12, 1'b0);
    step();
    issueValid = 1'b0; srcValid = 3'b111; srcData = {3{32'h1111_2222}};
    for (int k = 0; k < 5; k++) begin
      chk("t3_valid", 64'(wbValid), 1);
      chk("t3_data", 64'(wbData), 64'hDEAD_BEEF);
      chk("t3_rd", 64'(wbRd), 12);
      step();
    end
    srcValid = '0;
    wbReady = 1'b1;
    drive_issue(2'd0, 5'd13); set_src(0, 32'h0BAD_F00D); push(32'h0BAD_F00D, 5'd13, 1'b0);
    #1 chk("t3_ready", 64'(issueReady), 1);
    step();
    issueValid = 1'b0; srcValid = '0;
    chk("t3_next_valid", 64'(wbValid), 1);
    chk("t3_next_rd", 64'(wbRd), 13);
    step();

    // 4a: timeout after exactly T WAIT cycles
    drive_issue(2'd2, 5'd4); push(32'h0, 5'd4, 1'b1);
    step();
    issueValid = 1'b0;
    for (int k = 1; k <= T; k++) begin
      chk("t4_not_yet", 64'(wbValid), 0);
      step();
    end
    chk("t4_valid", 64'(wbValid), 1);
    chk("t4_err", 64'(wbErr), 1);
    chk("t4_data", 64'(wbData), 0);
    step();

    // 4b: result in the last WAIT cycle wins; other units ignored
    drive_issue(2'd2, 5'd5); push(32'hCAFE_0002, 5'd5, 1'b0);
    step();
    issueValid = 1'b0;
    step(); step(); step();
    set_src(0, 32'hAAAA_0000); set_src(1, 32'hBBBB_0001); set_src(2, 32'hCAFE_0002);
    step();
    srcValid = '0;
    chk("t4b_valid", 64'(wbValid), 1);
    chk("t4b_err", 64'(wbErr), 0);
    chk("t4b_data", 64'(wbData), 64'hCAFE_0002);
    step();

    // 5: bad select
    drive_issue(2'd3, 5'd6); srcValid = 3'b111; push(32'h0, 5'd6, 1'b1);
    step();
    issueValid = 1'b0; srcValid = '0;
    chk("t5_valid", 64'(wbValid), 1);
    chk("t5_err", 64'(wbErr), 1);
    chk("t5_data", 64'(wbData), 0);
    step();

    // 6: asynchronous reset during WAIT drops the op
    drive_issue(2'd1, 5'd8);
    step();
    issueValid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_wbValid", 64'(wbValid), 0);
    chk("t6_ready", 64'(issueReady), 1);
    chk("t6_stall", 64'(stall), 0);
    step();
    rst_n = 1'b1;
    set_src(1, 32'h7777_7777);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_no_result", 64'(wbValid), 0);
    end
    srcValid = '0;
    step();

    chk("sb_empty", 64'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
